// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry k is the pattern for hex digit k.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } seg_drive_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = $clog2(n);
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed hex driver for common-anode 7-segment displays with per-frame value latching.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks digits above the highest non-zero nibble.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned PW = clog2_min1(REFRESH_DIV);
  localparam int unsigned IW = clog2_min1(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]                presc;
  logic [IW-1:0]                idx;
  logic [NUM_DIGITS-1:0][3:0]   shadow_val;
  logic [NUM_DIGITS-1:0]        shadow_dp;

  logic                         tick_c;
  logic                         frame_end_c;
  logic [NUM_DIGITS-1:0]        lz_blank_c;
  logic [NUM_DIGITS-1:0]        hide_c;
  logic [3:0]                   nibble_c;
  logic [6:0]                   seg_dec_c;
  logic [NUM_DIGITS-1:0]        an_nxt_c;
  seg_drive_t                   drv_nxt_c;

  assign tick_c      = en && (presc == PRESC_LAST);
  assign frame_end_c = tick_c && (idx == IDX_LAST);

  // Prescaler, digit index and per-frame shadow; all hold while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else if (en) begin
      presc <= tick_c ? '0 : presc + PW'(1);
      if (tick_c) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
      if (frame_end_c) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Blank from the top down until the first non-zero shadow nibble; digit 0 never blanks.
  always_comb begin
    logic seen_nz;
    seen_nz    = 1'b0;
    lz_blank_c = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen_nz       = seen_nz | (shadow_val[i] != 4'h0);
      lz_blank_c[i] = !seen_nz;
    end
  end
`else
  assign lz_blank_c = '0;
`endif

  assign hide_c   = digit_mask | lz_blank_c;
  assign nibble_c = shadow_val[idx];

  seg7_hex_decoder u_dec (
    .nibble (nibble_c),
    .seg_c  (seg_dec_c)
  );

  always_comb begin
    an_nxt_c  = '1;
    drv_nxt_c = '{seg: SEG_BLANK, dp: 1'b1};
    if (en && !hide_c[idx]) begin
      an_nxt_c[idx] = 1'b0;
      drv_nxt_c.seg = seg_dec_c;
      drv_nxt_c.dp  = ~shadow_dp[idx];
    end
  end

  // Output register stage: one cycle behind the index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt_c;
      seg        <= drv_nxt_c.seg;
      dp         <= drv_nxt_c.dp;
      frame_done <= frame_end_c;
    end
  end

endmodule
